// File: rtl/fractal_sync_pkg.sv
// Shared definitions for the fractal_sync handshake arbiter: arbitration
// mode encoding and pointer sizing helper.
package fractal_sync_pkg;

  typedef enum logic [0:0] {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Round-robin pointer width; one bit minimum so a single-input build still has a legal vector.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fractal_sync_out_slot.sv
// One-entry output register with valid/ready handshake; the payload reads as
// zero whenever the slot is empty.
module fractal_sync_out_slot #(
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  load_i,
  input  data_t data_i,
  input  logic  ready_i,
  output logic  free_o,
  output logic  valid_o,
  output data_t data_o
);

  logic  valid_q;
  data_t data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end
  end

  // A slot being drained this cycle can be refilled in the same cycle.
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fractal_sync_hs_arbiter.sv
// Arbitrates IN_PORTS FIFO heads onto OUT_PORTS registered handshake slots.
// Optional per-input grant counters are built only when FRACTAL_SYNC_ARB_STATS_EN is defined.
module fractal_sync_hs_arbiter
  import fractal_sync_pkg::*;
#(
  parameter int  IN_PORTS  = 1,
  parameter int  OUT_PORTS = 1,
  parameter int  ARB_MODE  = 0,
  parameter int  CNT_W     = 8,
  parameter type arbiter_t = logic
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic [IN_PORTS-1:0]  pop_o,
  input  logic [IN_PORTS-1:0]  empty_i,
  input  arbiter_t             element_i   [IN_PORTS],
  output logic [OUT_PORTS-1:0] valid_o,
  input  logic [OUT_PORTS-1:0] ready_i,
  output arbiter_t             element_o   [OUT_PORTS],
  output logic [CNT_W-1:0]     grant_cnt_o [IN_PORTS]
);

  localparam int        PTR_W = ptr_width(IN_PORTS);
  localparam arb_mode_e MODE  = arb_mode_e'(ARB_MODE[0]);

  if (IN_PORTS <= 0) begin : g_bad_in
    $fatal(1, "fractal_sync_hs_arbiter: IN_PORTS must be > 0");
  end
  if (OUT_PORTS <= 0) begin : g_bad_out
    $fatal(1, "fractal_sync_hs_arbiter: OUT_PORTS must be > 0");
  end

  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IN_PORTS-1:0]  grant;
  logic [OUT_PORTS-1:0] slot_free, slot_load;
  logic [PTR_W-1:0]     slot_src [OUT_PORTS];

  // Slots are served in ascending order; each takes the first untaken requester in search order.
  always_comb begin
    int   base;
    int   idx;
    int   last_off;
    logic found;
    grant     = '0;
    slot_load = '0;
    base      = (MODE == ARB_RR) ? int'(rr_ptr_q) : 0;
    idx       = 0;
    last_off  = -1;
    found     = 1'b0;
    for (int j = 0; j < OUT_PORTS; j++) begin
      slot_src[j] = '0;
      found       = 1'b0;
      if (slot_free[j]) begin
        for (int k = 0; k < IN_PORTS; k++) begin
          idx = (base + k) % IN_PORTS;
          if (!found && !empty_i[idx] && !grant[idx]) begin
            found        = 1'b1;
            grant[idx]   = 1'b1;
            slot_load[j] = 1'b1;
            slot_src[j]  = PTR_W'(idx);
            if (k > last_off) last_off = k;
          end
        end
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (MODE == ARB_RR && last_off >= 0) begin
      rr_ptr_d = PTR_W'((base + last_off + 1) % IN_PORTS);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

  assign pop_o = grant & {IN_PORTS{rst_ni}};

  for (genvar j = 0; j < OUT_PORTS; j++) begin : g_slot
    fractal_sync_out_slot #(
      .data_t (arbiter_t)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (slot_load[j]),
      .data_i  (element_i[slot_src[j]]),
      .ready_i (ready_i[j]),
      .free_o  (slot_free[j]),
      .valid_o (valid_o[j]),
      .data_o  (element_o[j])
    );
  end

`ifdef FRACTAL_SYNC_ARB_STATS_EN
  for (genvar i = 0; i < IN_PORTS; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                       cnt_q <= '0;
      else if (grant[i] && cnt_q != '1)  cnt_q <= cnt_q + CNT_W'(1);
    end
    assign grant_cnt_o[i] = cnt_q;
  end
`else
  for (genvar i = 0; i < IN_PORTS; i++) begin : g_cnt
    assign grant_cnt_o[i] = '0;
  end
`endif

endmodule

// File: tb/tb_fractal_sync_hs_arbiter.sv
// Directed bench: four arbiter instances (RR 4x1, RR 4x2, RR 2x1, fixed 3x1)
// exercised in turn with hand-computed expectations.
module tb_fractal_sync_hs_arbiter;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // a: IN=4 OUT=1 RR CNT_W=2
  logic [3:0] a_pop, a_empty;
  logic [7:0] a_elem_i [4];
  logic [0:0] a_valid, a_ready;
  logic [7:0] a_elem_o [1];
  logic [1:0] a_cnt [4];
  // b: IN=4 OUT=2 RR
  logic [3:0] b_pop, b_empty;
  logic [7:0] b_elem_i [4];
  logic [1:0] b_valid, b_ready;
  logic [7:0] b_elem_o [2];
  logic [7:0] b_cnt [4];
  // c: IN=2 OUT=1 RR
  logic [1:0] c_pop, c_empty;
  logic [7:0] c_elem_i [2];
  logic [0:0] c_valid, c_ready;
  logic [7:0] c_elem_o [1];
  logic [7:0] c_cnt [2];
  // d: IN=3 OUT=1 fixed priority
  logic [2:0] d_pop, d_empty;
  logic [7:0] d_elem_i [3];
  logic [0:0] d_valid, d_ready;
  logic [7:0] d_elem_o [1];
  logic [7:0] d_cnt [3];

  fractal_sync_hs_arbiter #(.IN_PORTS(4), .OUT_PORTS(1), .ARB_MODE(0), .CNT_W(2),
    .arbiter_t(logic [7:0])) u_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .pop_o(a_pop), .empty_i(a_empty), .element_i(a_elem_i),
    .valid_o(a_valid), .ready_i(a_ready), .element_o(a_elem_o), .grant_cnt_o(a_cnt));

  fractal_sync_hs_arbiter #(.IN_PORTS(4), .OUT_PORTS(2), .ARB_MODE(0), .CNT_W(8),
    .arbiter_t(logic [7:0])) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .pop_o(b_pop), .empty_i(b_empty), .element_i(b_elem_i),
    .valid_o(b_valid), .ready_i(b_ready), .element_o(b_elem_o), .grant_cnt_o(b_cnt));

  fractal_sync_hs_arbiter #(.IN_PORTS(2), .OUT_PORTS(1), .ARB_MODE(0), .CNT_W(8),
    .arbiter_t(logic [7:0])) u_c (
    .clk_i(clk_i), .rst_ni(rst_ni), .pop_o(c_pop), .empty_i(c_empty), .element_i(c_elem_i),
    .valid_o(c_valid), .ready_i(c_ready), .element_o(c_elem_o), .grant_cnt_o(c_cnt));

  fractal_sync_hs_arbiter #(.IN_PORTS(3), .OUT_PORTS(1), .ARB_MODE(1), .CNT_W(8),
    .arbiter_t(logic [7:0])) u_d (
    .clk_i(clk_i), .rst_ni(rst_ni), .pop_o(d_pop), .empty_i(d_empty), .element_i(d_elem_i),
    .valid_o(d_valid), .ready_i(d_ready), .element_o(d_elem_o), .grant_cnt_o(d_cnt));

`ifdef FRACTAL_SYNC_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni  = 1'b0;
    a_empty = 4'b0000; b_empty = 4'b1111; c_empty = 2'b11; d_empty = 3'b111;
    a_ready = 1'b1;    b_ready = 2'b11;   c_ready = 1'b1;  d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_elem_i[i] = 8'(8'h10 + i);
      b_elem_i[i] = 8'(8'h10 + i);
    end
    for (int i = 0; i < 2; i++) c_elem_i[i] = 8'(8'h10 + i);
    for (int i = 0; i < 3; i++) d_elem_i[i] = 8'(8'h10 + i);

    // reset state, with input requests present
    step();
    check_val("rst_valid", 32'(a_valid), 32'd0);
    check_val("rst_elem", 32'(a_elem_o[0]), 32'd0);
    check_val("rst_pop", 32'(a_pop), 32'd0);
    check_val("rst_cnt0", 32'(a_cnt[0]), 32'd0);

    // a: round-robin 0,1,2,3,0 with single slot
    rst_ni = 1'b1;
    #1;
    check_val("a_pop_c0", 32'(a_pop), 32'b0001);
    step();
    check_val("a_valid_c1", 32'(a_valid), 32'd1);
    check_val("a_elem_c1", 32'(a_elem_o[0]), 32'h10);
    check_val("a_pop_c1", 32'(a_pop), 32'b0010);
    step();
    check_val("a_elem_c2", 32'(a_elem_o[0]), 32'h11);
    check_val("a_pop_c2", 32'(a_pop), 32'b0100);
    step();
    check_val("a_elem_c3", 32'(a_elem_o[0]), 32'h12);
    check_val("a_pop_c3", 32'(a_pop), 32'b1000);
    step();
    check_val("a_elem_c4", 32'(a_elem_o[0]), 32'h13);
    check_val("a_pop_c4", 32'(a_pop), 32'b0001);
    step();
    check_val("a_elem_c5", 32'(a_elem_o[0]), 32'h10);
    check_val("a_valid_c5", 32'(a_valid), 32'd1);

    // only input 0 requests: three more grants -> five total, counter saturates at 3
    a_empty = 4'b1110;
    #1;
    check_val("a_pop_only0", 32'(a_pop), 32'b0001);
    step(); step(); step();
    check_val("a_cnt0_sat", 32'(a_cnt[0]), STATS ? 32'd3 : 32'd0);
    check_val("a_cnt1", 32'(a_cnt[1]), STATS ? 32'd1 : 32'd0);
    a_empty = 4'b1111;
    step();

    // b: two slots, grants {0,1},{2,3},{0,1}
    b_empty = 4'b0000;
    #1;
    check_val("b_pop_c0", 32'(b_pop), 32'b0011);
    step();
    check_val("b_pop_c1", 32'(b_pop), 32'b1100);
    check_val("b_valid_c1", 32'(b_valid), 32'b11);
    check_val("b_elem0_c1", 32'(b_elem_o[0]), 32'h10);
    check_val("b_elem1_c1", 32'(b_elem_o[1]), 32'h11);
    step();
    check_val("b_pop_c2", 32'(b_pop), 32'b0011);
    check_val("b_elem0_c2", 32'(b_elem_o[0]), 32'h12);
    check_val("b_elem1_c2", 32'(b_elem_o[1]), 32'h13);
    step();
    check_val("b_elem0_c3", 32'(b_elem_o[0]), 32'h10);
    check_val("b_elem1_c3", 32'(b_elem_o[1]), 32'h11);
    b_empty = 4'b1111;
    #1;
    check_val("b_pop_idle", 32'(b_pop), 32'd0);
    step();
    check_val("b_valid_drain", 32'(b_valid), 32'b00);
    check_val("b_elem0_drain", 32'(b_elem_o[0]), 32'd0);

    // c: back-pressure holds slot, pointer and pops
    c_empty = 2'b00;
    #1;
    check_val("c_pop_c0", 32'(c_pop), 32'b01);
    step();
    check_val("c_valid_c1", 32'(c_valid), 32'd1);
    check_val("c_elem_c1", 32'(c_elem_o[0]), 32'h10);
    c_ready = 1'b0;
    #1;
    check_val("c_pop_stall", 32'(c_pop), 32'b00);
    for (int n = 0; n < 3; n++) begin
      step();
      check_val("c_pop_hold", 32'(c_pop), 32'b00);
      check_val("c_elem_hold", 32'(c_elem_o[0]), 32'h10);
      check_val("c_valid_hold", 32'(c_valid), 32'd1);
    end
    c_ready = 1'b1;
    #1;
    check_val("c_pop_resume", 32'(c_pop), 32'b10);
    step();
    check_val("c_elem_resume", 32'(c_elem_o[0]), 32'h11);
    c_empty = 2'b11;
    step();

    // d: fixed priority, inputs 1 and 2 requesting -> input 1 always wins
    d_empty = 3'b001;
    for (int n = 0; n < 3; n++) begin
      #1;
      check_val("d_pop_fixed", 32'(d_pop), 32'b010);
      step();
      check_val("d_elem_fixed", 32'(d_elem_o[0]), 32'h11);
    end
    d_empty = 3'b111;

    // a: asynchronous reset while busy
    a_empty = 4'b0000;
    step(); step();
    check_val("a_busy_valid", 32'(a_valid), 32'd1);
    rst_ni = 1'b0;
    #1;
    check_val("arst_valid", 32'(a_valid), 32'd0);
    check_val("arst_elem", 32'(a_elem_o[0]), 32'd0);
    check_val("arst_pop", 32'(a_pop), 32'd0);
    check_val("arst_cnt0", 32'(a_cnt[0]), 32'd0);
    step();
    rst_ni = 1'b1;
    #1;
    check_val("post_rst_pop", 32'(a_pop), 32'b0001);
    step();
    check_val("post_rst_elem", 32'(a_elem_o[0]), 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
